vga_rx_monitor: RTL and testbench
=================================

# vga_rx_monitor

Receive-side checker for the VGA pixel stream driven by the sprite engine. It samples the 25 MHz pixel clock, syncs, blank and RGB in the 50 MHz system domain and recovers per-pixel x/y coordinates. It measures line and frame geometry, declares lock once two consecutive frames match, and exposes the measurements plus a frame checksum through an Avalon-MM slave for the HPS and testbenches.

## Interface
- No parameters.
- clk  in  1  50 MHz system clock; all VGA inputs are synchronous to it.
- reset  in  1  asynchronous, active-high.
- vga_clk  in  1  pixel clock, 25 MHz (toggles every clk).
- vga_hs, vga_vs  in  1 each  active-low syncs.
- vga_blank_n  in  1  high during active video.
- vga_r, vga_g, vga_b  in  8 each  pixel colour.
- chipselect, read, write  in  1 each  Avalon-MM slave controls.
- address  in  3  register index.
- writedata  in  32  write data (only address 5 is writable).
- readdata  out  32  registered read data.
- pix_valid  out  1  one-clk pulse, recovered active pixel.
- pix_x  out  10  active column of the pulsed pixel.
- pix_y  out  9  active row of the pulsed pixel.
- pix_rgb  out  24  {r,g,b} of the pulsed pixel.
- locked  out  1  geometry locked.

## Operation
- Strobe: vga_clk_q registers vga_clk. stb = vga_clk & ~vga_clk_q. All sampling and counting happens only on stb cycles. hs_q and vs_q hold the previous strobe's values.
- Line start: on stb with hs_q=1 and vga_hs=0 (hs_fall).
  - h_cnt (12b) clears to 0 on hs_fall and increments on other strobes. At hs_fall, meas_h_total <= h_cnt+1.
  - act_cnt (12b) counts strobes with blank_n=1 and clears on hs_fall. At hs_fall, if act_cnt≠0, meas_h_active <= act_cnt and line_act <= 1.
- Frame start: on stb with vs_q=1 and vga_vs=0 (vs_fall).
  - v_cnt (11b) counts hs_falls since the last vs_fall. vact_cnt (11b) counts hs_falls that closed a line with act_cnt≠0.
  - At vs_fall: latch v_total <= v_cnt and v_active <= vact_cnt, then clear both counters.
- Pixel output: on stb with blank_n=1, the next clk asserts pix_valid for one cycle with pix_x = act_cnt (pre-increment), pix_y = vact_cnt, and pix_rgb = sampled colour. pix_x saturates at 1023; pix_y saturates at 511.
- Checksum: a 32-bit wrapping sum of r+g+b over active pixels. At vs_fall it is latched to reg 6 and then cleared.
- frame_cnt: 32-bit wrapping count of vs_falls.
- Lock FSM, states SEARCH, MEASURE, CHECK, LOCKED:
  - SEARCH → MEASURE on the first vs_fall. Nothing is latched from that partial frame.
  - MEASURE → CHECK on the next vs_fall. This frame's geometry is stored as ref.
  - CHECK: on the next vs_fall, go to LOCKED if the new geometry equals ref, otherwise stay in CHECK with ref updated.
  - LOCKED: on each vs_fall, stay if the geometry equals ref. On mismatch go to CHECK, update ref, and increment err_cnt (8b, saturating at 255).
  - locked = (state==LOCKED).
- Registers (read):
  - 0: h_total.
  - 1: h_active.
  - 2: v_total.
  - 3: v_active.
  - 4: frame_cnt.
  - 5: {16'b0, err_cnt, 7'b0, locked}.
  - 6: checksum.
  - 7: 0.
- Write to address 5 clears err_cnt. Writes to any other address are ignored.
- Simultaneous events: if hs_fall and vs_fall fall on the same stb, the hs_fall update is applied first, then the vs_fall latch uses the incremented v_cnt and vact_cnt.

## Timing
- Reset: all counters, measurements, checksum, frame_cnt, err_cnt, readdata, pix_* and locked = 0; FSM in SEARCH.
- Reset asserted mid-frame discards everything. Lock needs 3 vs_falls after release.
- Read latency: readdata is valid on the clk after the cycle with chipselect&read, and holds until the next read.
- pix_valid: 1 clk after the sampling stb, giving at most one pulse per 2 clks.
- Measurement registers and locked update 1 clk after the stb that carries vs_fall or hs_fall.
- Read and write to address 5 in the same cycle: readdata returns the pre-clear value.

## Test plan
- Standard 640x480 stream (800 px/line, 640 active, HS low 96 px, 525 lines, 480 active, VS low 2 lines), solid {00,00,80} → after the 3rd vs_fall: locked=1, regs 0–3 read 800/640/525/480, reg 6 = 0x02580000.
- Same stream, check the last active pixel of a frame → pix_x=639, pix_y=479, pix_valid pulses exactly 307200 times per frame.
- While locked, lengthen one line to 801 px → at that frame's vs_fall: locked=0, err_cnt=1. It relocks after the next matching frame.
- Write address 5 with err_cnt=3 → the next read of reg 5 returns 0 (plus the lock bit).
- Assert reset mid-frame 10 → all registers read 0, and locked stays 0 until 3 vs_falls later.
- Hold vga_clk constant for 1000 clks → no pix_valid pulses and no counter changes.

Source files
------------

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: receive-side checker for the sprite engine's VGA stream.
// Recovers pixel coordinates, measures line/frame geometry, tracks lock
// against a reference geometry and exposes results on an Avalon-MM slave.
module vga_rx_monitor (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_clk,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        locked
);

  typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCKED} lock_state_t;

  lock_state_t state, state_nx;
  logic        ref_load, err_inc;

  logic        vga_clk_q, hs_q, vs_q;
  logic        stb, hs_fall, vs_fall, line_has_act, err_clr;
  logic [11:0] h_cnt, act_cnt, h_total, h_active, h_total_nx, h_active_nx;
  logic [10:0] v_cnt, vact_cnt, v_total, v_active, v_cnt_nx, vact_nx;
  logic [9:0]  pix_sum;
  logic [31:0] sum, sum_nx, checksum, frame_cnt, rd_mux;
  logic [7:0]  err_cnt;
  logic [45:0] geom_ref, geom_nx;
  logic        geom_match;
  logic        unused_wdata;

  // Only the address decode of a write matters; its data is ignored.
  assign unused_wdata = ^writedata;

  // A strobe is the rising edge of the pixel clock seen in the clk domain.
  assign stb     = vga_clk & ~vga_clk_q;
  assign hs_fall = stb & hs_q & ~vga_hs;
  assign vs_fall = stb & vs_q & ~vga_vs;

  // Next-value views so a vs_fall on the same strobe as an hs_fall sees
  // the line that hs_fall just closed.
  assign line_has_act = (act_cnt != 12'd0);
  assign h_total_nx   = hs_fall ? (h_cnt + 12'd1) : h_total;
  assign h_active_nx  = (hs_fall && line_has_act) ? act_cnt : h_active;
  assign v_cnt_nx     = v_cnt + {10'd0, hs_fall};
  assign vact_nx      = vact_cnt + {10'd0, hs_fall & line_has_act};
  assign pix_sum      = {2'b00, vga_r} + {2'b00, vga_g} + {2'b00, vga_b};
  assign sum_nx       = (stb & vga_blank_n) ? (sum + {22'd0, pix_sum}) : sum;
  assign geom_nx      = {h_total_nx, h_active_nx, v_cnt_nx, vact_nx};
  assign geom_match   = (geom_nx == geom_ref);
  assign err_clr      = chipselect & write & (address == 3'd5);
  assign locked       = (state == LOCKED);

  // Pixel-clock edge detector and previous-strobe sync samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_clk_q <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      vga_clk_q <= vga_clk;
      if (stb) begin
        hs_q <= vga_hs;
        vs_q <= vga_vs;
      end
    end
  end

  // Horizontal counters and per-line measurements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt    <= 12'd0;
      act_cnt  <= 12'd0;
      h_total  <= 12'd0;
      h_active <= 12'd0;
    end else begin
      h_total  <= h_total_nx;
      h_active <= h_active_nx;
      if (stb) begin
        if (hs_fall) begin
          h_cnt   <= 12'd0;
          act_cnt <= 12'd0;
        end else begin
          h_cnt <= h_cnt + 12'd1;
          if (vga_blank_n) act_cnt <= act_cnt + 12'd1;
        end
      end
    end
  end

  // Vertical counters, checksum and frame count; latched at each vs_fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_cnt     <= 11'd0;
      vact_cnt  <= 11'd0;
      v_total   <= 11'd0;
      v_active  <= 11'd0;
      sum       <= 32'd0;
      checksum  <= 32'd0;
      frame_cnt <= 32'd0;
    end else if (vs_fall) begin
      v_total   <= v_cnt_nx;
      v_active  <= vact_nx;
      checksum  <= sum_nx;
      v_cnt     <= 11'd0;
      vact_cnt  <= 11'd0;
      sum       <= 32'd0;
      frame_cnt <= frame_cnt + 32'd1;
    end else begin
      v_cnt    <= v_cnt_nx;
      vact_cnt <= vact_nx;
      sum      <= sum_nx;
    end
  end

  // Recovered pixel output, one clk after the sampling strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_x     <= 10'd0;
      pix_y     <= 9'd0;
      pix_rgb   <= 24'd0;
    end else begin
      pix_valid <= stb & vga_blank_n;
      if (stb & vga_blank_n) begin
        pix_x   <= (act_cnt > 12'd1023) ? 10'd1023 : act_cnt[9:0];
        pix_y   <= (vact_cnt > 11'd511) ? 9'd511 : vact_cnt[8:0];
        pix_rgb <= {vga_r, vga_g, vga_b};
      end
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SEARCH;
    else       state <= state_nx;
  end

  // Lock FSM next state; the first vs_fall only arms measurement.
  always_comb begin
    state_nx = state;
    ref_load = 1'b0;
    err_inc  = 1'b0;
    if (vs_fall) begin
      case (state)
        SEARCH:  state_nx = MEASURE;
        MEASURE: begin
          state_nx = CHECK;
          ref_load = 1'b1;
        end
        CHECK: begin
          ref_load = 1'b1;
          if (geom_match) state_nx = LOCKED;
        end
        LOCKED: begin
          if (!geom_match) begin
            state_nx = CHECK;
            ref_load = 1'b1;
            err_inc  = 1'b1;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  // Reference geometry and saturating lock-loss counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      geom_ref <= 46'd0;
      err_cnt  <= 8'd0;
    end else begin
      if (ref_load) geom_ref <= geom_nx;
      if (err_clr)                           err_cnt <= 8'd0;
      else if (err_inc && err_cnt != 8'hff)  err_cnt <= err_cnt + 8'd1;
    end
  end

  // Register file read mux.
  always_comb begin
    case (address)
      3'd0:    rd_mux = {20'd0, h_total};
      3'd1:    rd_mux = {20'd0, h_active};
      3'd2:    rd_mux = {21'd0, v_total};
      3'd3:    rd_mux = {21'd0, v_active};
      3'd4:    rd_mux = frame_cnt;
      3'd5:    rd_mux = {16'd0, err_cnt, 7'd0, locked};
      3'd6:    rd_mux = checksum;
      default: rd_mux = 32'd0;
    endcase
  end

  // Registered read data, held until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  readdata <= 32'd0;
    else if (chipselect & read) readdata <= rd_mux;
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: directed bench for vga_rx_monitor on a small
// geometry (20 px/line, HS low 3 px, 12 active from px 5; 8 lines,
// VS low 2 lines, 4 active from line 3).
module tb_vga_rx_monitor;

  logic        clk, reset, vga_clk, vga_hs, vga_vs, vga_blank_n;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        chipselect, read, write;
  logic [2:0]  address;
  logic [31:0] writedata, readdata;
  logic        pix_valid, locked;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [23:0] pix_rgb;

  int checks = 0;
  int passes = 0;
  int px_bad = 0;
  int pulse_cnt = 0;
  int last_x = 0;
  int last_y = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int          extra;
    logic [23:0] rgb;
    logic        exp_locked;
    logic [31:0] exp_h_total;
    logic [7:0]  exp_err;
    logic [31:0] exp_sum;
  } frame_vec_t;

  vga_rx_monitor dut (
    .clk(clk), .reset(reset), .vga_clk(vga_clk), .vga_hs(vga_hs),
    .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_r(vga_r),
    .vga_g(vga_g), .vga_b(vga_b), .chipselect(chipselect), .read(read),
    .write(write), .address(address), .writedata(writedata),
    .readdata(readdata), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_rgb(pix_rgb), .locked(locked)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end, required finish");
    $fatal(1, "watchdog expired");
  end

  // Counts every pix_valid pulse independently of the driver.
  always @(negedge clk) if (pix_valid === 1'b1) pulse_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  // Reads all eight registers against the eight values queued in exp_q.
  task automatic check_regs(input string tag);
    logic [31:0] d, e;
    for (int a = 0; a < 8; a++) begin
      read_reg(a[2:0], d);
      e = exp_q.pop_front();
      check($sformatf("%s reg%0d", tag, a), d, e);
    end
  endtask

  task automatic push_regs(input logic [31:0] h, input logic [31:0] fc,
                           input logic [31:0] r5, input logic [31:0] cs);
    exp_q.push_back(h);
    exp_q.push_back(32'd12);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd4);
    exp_q.push_back(fc);
    exp_q.push_back(r5);
    exp_q.push_back(cs);
    exp_q.push_back(32'd0);
  endtask

  // One pixel period: strobe on the first clk, pixel output checked after it.
  task automatic drive_px(input logic hs, input logic vs, input logic blank,
                          input logic [23:0] rgb, input int x, input int y);
    @(negedge clk);
    vga_clk = 1'b1; vga_hs = hs; vga_vs = vs; vga_blank_n = blank;
    {vga_r, vga_g, vga_b} = rgb;
    @(negedge clk);
    vga_clk = 1'b0;
    if (blank) begin
      if (pix_valid !== 1'b1 || pix_x !== x[9:0] || pix_y !== y[8:0] || pix_rgb !== rgb)
        px_bad++;
      last_x = int'(pix_x);
      last_y = int'(pix_y);
    end else if (pix_valid !== 1'b0) begin
      px_bad++;
    end
  endtask

  // Frame rotated so it ends with the hs_fall+vs_fall strobe that closes it.
  task automatic drive_frame(input int extra, input logic [23:0] rgb, input int nlines);
    px_bad = 0;
    for (int ln = 0; ln < nlines; ln++) begin
      for (int px = 0; px < 20 + ((ln == 7) ? extra : 0); px++) begin
        if (!(ln == 0 && px == 0))
          drive_px(px >= 3, ln >= 2, (ln >= 3) && (ln < 7) && (px >= 5) && (px < 17),
                   rgb, px - 5, ln - 3);
      end
    end
    if (nlines == 8) drive_px(1'b0, 1'b0, 1'b0, rgb, 0, 0);
  endtask

  initial begin
    frame_vec_t vecs [13];
    logic [31:0] d;
    int p0;

    reset = 1'b1; vga_clk = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1; vga_blank_n = 1'b0;
    vga_r = 8'd0; vga_g = 8'd0; vga_b = 8'd0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0; address = 3'd0; writedata = 32'd0;

    //            extra rgb          lock h_tot err  checksum
    vecs[0]  = '{0, 24'h000080, 1'b0, 32'd20, 8'd0, 32'd6144};
    vecs[1]  = '{0, 24'h000080, 1'b0, 32'd20, 8'd0, 32'd6144};
    vecs[2]  = '{0, 24'h000080, 1'b1, 32'd20, 8'd0, 32'd6144};
    vecs[3]  = '{0, 24'h102030, 1'b1, 32'd20, 8'd0, 32'd4608};
    vecs[4]  = '{1, 24'h000080, 1'b0, 32'd21, 8'd1, 32'd6144};
    vecs[5]  = '{0, 24'hffffff, 1'b0, 32'd20, 8'd1, 32'd36720};
    vecs[6]  = '{0, 24'h000080, 1'b1, 32'd20, 8'd1, 32'd6144};
    vecs[7]  = '{1, 24'h010203, 1'b0, 32'd21, 8'd2, 32'd288};
    vecs[8]  = '{0, 24'h000080, 1'b0, 32'd20, 8'd2, 32'd6144};
    vecs[9]  = '{0, 24'h000080, 1'b1, 32'd20, 8'd2, 32'd6144};
    vecs[10] = '{1, 24'h000080, 1'b0, 32'd21, 8'd3, 32'd6144};
    vecs[11] = '{0, 24'h000080, 1'b0, 32'd20, 8'd3, 32'd6144};
    vecs[12] = '{0, 24'h000080, 1'b1, 32'd20, 8'd3, 32'd6144};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst pix_valid", {31'd0, pix_valid}, 32'd0);
    check("rst pix_x", {22'd0, pix_x}, 32'd0);
    check("rst pix_y", {23'd0, pix_y}, 32'd0);
    check("rst pix_rgb", {8'd0, pix_rgb}, 32'd0);
    check("rst locked", {31'd0, locked}, 32'd0);
    check("rst readdata", readdata, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 8; a++) exp_q.push_back(32'd0);
    check_regs("rst");

    // Table of frames
    for (int i = 0; i < 13; i++) begin
      p0 = pulse_cnt;
      drive_frame(vecs[i].extra, vecs[i].rgb, 8);
      check($sformatf("f%0d pix_pulses", i), pulse_cnt - p0, 32'd48);
      check($sformatf("f%0d pix_bad", i), px_bad, 32'd0);
      check($sformatf("f%0d last_xy", i), {last_x[15:0], last_y[15:0]}, {16'd11, 16'd3});
      check($sformatf("f%0d locked", i), {31'd0, locked}, {31'd0, vecs[i].exp_locked});
      push_regs(vecs[i].exp_h_total, i + 1,
                {16'd0, vecs[i].exp_err, 7'd0, vecs[i].exp_locked}, vecs[i].exp_sum);
      check_regs($sformatf("f%0d", i));
    end

    // Pixel clock stalled: inputs wiggle but nothing may be sampled
    p0 = pulse_cnt;
    repeat (1000) begin
      @(negedge clk);
      vga_hs = 1'($urandom_range(0, 1));
      vga_vs = 1'($urandom_range(0, 1));
      vga_blank_n = 1'($urandom_range(0, 1));
      vga_r = 8'($urandom_range(0, 255));
    end
    check("hold pulses", pulse_cnt - p0, 32'd0);
    push_regs(32'd20, 32'd13, 32'h301, 32'd6144);
    check_regs("hold");
    drive_frame(0, 24'h000080, 8);
    check("post_hold locked", {31'd0, locked}, 32'd1);
    push_regs(32'd20, 32'd14, 32'h301, 32'd6144);
    check_regs("post_hold");

    // Writes elsewhere are ignored; read+write of reg 5 returns pre-clear value
    write_reg(3'd3, 32'hffff_ffff);
    read_reg(3'd5, d);
    check("wr3 ignored", d, 32'h301);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 3'd5;
    writedata = $urandom;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    check("rw5 pre-clear", readdata, 32'h301);
    read_reg(3'd5, d);
    check("reg5 cleared", d, 32'h001);

    // Reset mid-frame discards everything
    drive_frame(0, 24'h000080, 5);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst locked", {31'd0, locked}, 32'd0);
    check("mid_rst pix_valid", {31'd0, pix_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 8; a++) exp_q.push_back(32'd0);
    check_regs("mid_rst");
    for (int k = 0; k < 3; k++) begin
      drive_frame(0, 24'h000080, 8);
      check($sformatf("relock%0d locked", k), {31'd0, locked}, (k == 2) ? 32'd1 : 32'd0);
      read_reg(3'd4, d);
      check($sformatf("relock%0d frame_cnt", k), d, k + 1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
